rx_cmd_ctrl: RTL and testbench
==============================

RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the received and transmitted data.
REQ-002 Parameter ADDR_W, default 4, register-file address width.
REQ-003 Parameter FUN_W, default 4, ALU function-code width.
REQ-004 CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 RX_P_DATA  input  DATA_W  received byte from the UART receiver.
REQ-007 RX_D_VLD  input  1  one-cycle strobe; RX_P_DATA is valid in that cycle.
REQ-008 RF_RdData  input  DATA_W  register-file read data.
REQ-009 RF_RdData_VLD  input  1  one-cycle strobe qualifying RF_RdData.
REQ-010 ALU_OUT  input  2*DATA_W  ALU result.
REQ-011 ALU_OUT_VLD  input  1  one-cycle strobe qualifying ALU_OUT.
REQ-012 FIFO_FULL  input  1  high when the transmit FIFO cannot accept a byte.
REQ-013 RF_Address  output  ADDR_W  register-file address.
REQ-014 RF_WrEn / RF_RdEn  output  1 each  one-cycle write and read strobes.
REQ-015 RF_WrData  output  DATA_W  register-file write data.
REQ-016 ALU_FUN  output  FUN_W  ALU function code.
REQ-017 ALU_EN  output  1  one-cycle ALU start strobe.
REQ-018 CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-019 TX_P_DATA  output  DATA_W  byte pushed to the transmit FIFO.
REQ-020 TX_D_VLD  output  1  one-cycle FIFO write strobe.

Function
REQ-021 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI.
REQ-022 The controller shall consume a byte only in a cycle where RX_D_VLD=1 and the state is one of IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB or FUN; all other RX bytes shall be dropped.
REQ-023 IDLE decodes the command byte:
- 0xAA -> WR_ADDR
- 0xBB -> RD_ADDR
- 0xCC -> OPA
- 0xDD -> FUN
- any other value shall be ignored, and the state shall remain IDLE.
REQ-024 WR_ADDR shall latch RX_P_DATA[ADDR_W-1:0] as the address and then go to WR_DATA.
REQ-025 In WR_DATA, on the received byte, the next cycle shall drive RF_WrEn=1 for exactly one cycle with the latched address and RF_WrData=byte, then return to IDLE.
REQ-026 In RD_ADDR, on the received byte, the next cycle shall drive RF_RdEn=1 for one cycle with RF_Address=byte[ADDR_W-1:0], then go to RD_WAIT.
REQ-027 RD_WAIT shall capture RF_RdData on RF_RdData_VLD and then go to SEND_RD.
REQ-028 OPA shall write the byte to address 0, and OPB shall write the byte to address 1, using the same one-cycle RF_WrEn timing as REQ-025.
REQ-029 In FUN, on the received byte, ALU_FUN shall latch byte[FUN_W-1:0], and the next cycle shall pulse ALU_EN for one cycle, then go to ALU_WAIT.
REQ-030 CLK_GATE_EN shall be 1 from the cycle after the FUN byte is accepted through the cycle in which ALU_OUT_VLD is seen.
REQ-031 ALU_WAIT shall capture ALU_OUT on ALU_OUT_VLD and then go to SEND_LO.
REQ-032 In each SEND state, TX_D_VLD shall be 1 for exactly one cycle, in the first cycle where FIFO_FULL=0; the state shall be held while FIFO_FULL=1, and TX_D_VLD shall be 0 in those cycles.
REQ-033 SEND_RD shall send the captured read byte and then return to IDLE.
REQ-034 SEND_LO shall send ALU_OUT[DATA_W-1:0] and then go to SEND_HI.
REQ-035 SEND_HI shall send ALU_OUT[2*DATA_W-1:DATA_W] and then return to IDLE.
REQ-036 RF_WrEn, RF_RdEn and ALU_EN shall never be asserted in the same cycle.
REQ-037 TX_P_DATA shall be stable whenever TX_D_VLD=1.
REQ-038 The controller shall have no timeout: RD_WAIT and ALU_WAIT shall wait indefinitely for their valid strobe.

Reset
REQ-039 RST=0 shall immediately force state IDLE and drive all outputs and internal registers to 0, including in mid-command or mid-send.
REQ-040 After reset release, the first accepted byte shall be decoded as a command.

Verification
REQ-041 Write: send bytes AA, 05, 3C -> a single RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C; the controller ends in IDLE; TX_D_VLD stays 0.
REQ-042 Read: send BB, 07; return RF_RdData=0x5A with VLD 3 cycles after RF_RdEn -> one RF_RdEn pulse at address 7, then one TX_D_VLD with TX_P_DATA=0x5A.
REQ-043 ALU with operands: send CC, 12, 34, 02; return ALU_OUT=0x0468 -> RF writes (0,0x12) and (1,0x34); ALU_EN pulses once with ALU_FUN=2; CLK_GATE_EN is high through ALU_OUT_VLD; TX bytes are 0x68 then 0x04.
REQ-044 Backpressure: send DD, 01 with FIFO_FULL=1 for 10 cycles after ALU_OUT_VLD -> no TX_D_VLD during those cycles; then 0x68 and 0x04 are sent in consecutive free cycles.
REQ-045 Robustness: send byte 0x77 in IDLE -> no outputs change; send a byte during ALU_WAIT -> it is dropped; assert RST during SEND_HI -> all outputs are 0 and the next AA frame completes normally.

Source files
------------

// File: rtl/rx_cmd_ctrl.sv
// UART command controller: decodes RX command frames into register-file writes/reads and ALU operations, and returns results as TX bytes.
// Latency: strobes are registered and appear one cycle after the byte that triggers them; a TX byte is written in the same cycle FIFO_FULL is low.
// Backpressure: SEND states hold while FIFO_FULL=1; bytes arriving outside the byte-consuming states are dropped; waits on RF/ALU have no timeout.
module rx_cmd_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_W-1:0]     RF_RdData,
    input  logic                  RF_RdData_VLD,
    input  logic [2*DATA_W-1:0]   ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic                  FIFO_FULL,
    output logic [ADDR_W-1:0]     RF_Address,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [DATA_W-1:0]     RF_WrData,
    output logic [FUN_W-1:0]      ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CLK_GATE_EN,
    output logic [DATA_W-1:0]     TX_P_DATA,
    output logic                  TX_D_VLD
);

    localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_OPS = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_FUN = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        SEND_RD  = 4'd9,
        SEND_LO  = 4'd10,
        SEND_HI  = 4'd11
    } state_t;

    state_t              r_state;
    // Upper ALU byte parked here while the lower byte is waiting to be sent.
    logic [DATA_W-1:0]   r_alu_hi;
    logic                w_in_send;

    // TX_D_VLD follows FIFO_FULL combinationally so a byte is never written into a
    // FIFO that went full in the same cycle; TX_P_DATA itself is registered and
    // loaded before the SEND state is entered, so it is stable while valid is high.
    assign w_in_send = (r_state == SEND_RD) || (r_state == SEND_LO) || (r_state == SEND_HI);
    assign TX_D_VLD  = w_in_send && !FIFO_FULL;

    // Command FSM with registered strobes, address/data, ALU function and TX byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_alu_hi    <= '0;
            RF_Address  <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_WrData   <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
        end else begin
            // Strobes are single-cycle: cleared every cycle unless re-armed below.
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:  r_state <= WR_ADDR;
                            CMD_RD:  r_state <= RD_ADDR;
                            CMD_OPS: r_state <= OPA;
                            CMD_FUN: r_state <= FUN;
                            default: r_state <= IDLE;
                        endcase
                    end
                end

                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR_W-1:0];
                        r_state    <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn   <= 1'b1;
                        RF_WrData <= RX_P_DATA;
                        r_state   <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= RX_P_DATA[ADDR_W-1:0];
                        r_state    <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        TX_P_DATA <= RF_RdData;
                        r_state   <= SEND_RD;
                    end
                end

                // Operand A always lands in register 0.
                OPA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= '0;
                        RF_WrData  <= RX_P_DATA;
                        r_state    <= OPB;
                    end
                end

                // Operand B always lands in register 1, then the function byte follows.
                OPB: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_W'(1);
                        RF_WrData  <= RX_P_DATA;
                        r_state    <= FUN;
                    end
                end

                // The ALU clock is ungated together with the start strobe.
                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN     <= RX_P_DATA[FUN_W-1:0];
                        ALU_EN      <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        r_state     <= ALU_WAIT;
                    end
                end

                // Gate stays open through the result cycle, closes on the next edge.
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        TX_P_DATA   <= ALU_OUT[DATA_W-1:0];
                        r_alu_hi    <= ALU_OUT[2*DATA_W-1:DATA_W];
                        CLK_GATE_EN <= 1'b0;
                        r_state     <= SEND_LO;
                    end
                end

                SEND_RD: begin
                    if (!FIFO_FULL) begin
                        r_state <= IDLE;
                    end
                end

                SEND_LO: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_alu_hi;
                        r_state   <= SEND_HI;
                    end
                end

                SEND_HI: begin
                    if (!FIFO_FULL) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
module tb_rx_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [DW-1:0]   RX_P_DATA = '0;
    logic            RX_D_VLD = 1'b0;
    logic [DW-1:0]   RF_RdData = '0;
    logic            RF_RdData_VLD = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic            ALU_OUT_VLD = 1'b0;
    logic            FIFO_FULL = 1'b0;
    logic [AW-1:0]   RF_Address;
    logic            RF_WrEn;
    logic            RF_RdEn;
    logic [DW-1:0]   RF_WrData;
    logic [FW-1:0]   ALU_FUN;
    logic            ALU_EN;
    logic            CLK_GATE_EN;
    logic [DW-1:0]   TX_P_DATA;
    logic            TX_D_VLD;

    rx_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_FULL(FIFO_FULL),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_WrData(RF_WrData), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int alu_lat = 2;
    logic [2*DW-1:0] alu_val = '0;
    logic [DW-1:0]   rd_val = '0;
    bit              g_model = 1'b0;

    // Scoreboard queues: filled when stimulus is driven, drained by the monitor.
    logic [AW+DW-1:0] wr_q[$];
    logic [AW-1:0]    rd_q[$];
    logic [FW-1:0]    fun_q[$];
    logic [DW-1:0]    tx_q[$];
    int               tx_cyc[$];

    logic [AW+DW-1:0] exp_wr;
    logic [AW-1:0]    exp_rd;
    logic [FW-1:0]    exp_fun;
    logic [DW-1:0]    exp_tx;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Monitor: every strobe must match the head of its queue.
    always @(negedge CLK) begin
        if (!RST) begin
            g_model = 1'b0;
        end else begin
            if (ALU_EN) g_model = 1'b1;
            checks++;
            if (CLK_GATE_EN !== g_model) begin
                errors++;
                $display("FAIL clk_gate_en cyc %0d: got %b required %b", cyc, CLK_GATE_EN, g_model);
            end
            if (ALU_OUT_VLD && g_model) g_model = 1'b0;

            if ($countones({RF_WrEn, RF_RdEn, ALU_EN}) > 1) begin
                errors++;
                $display("FAIL strobe_exclusive cyc %0d: got wr=%b rd=%b alu=%b required at most one",
                         cyc, RF_WrEn, RF_RdEn, ALU_EN);
            end
            if (RF_WrEn) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write cyc %0d: got addr %h data %h required no write", cyc, RF_Address, RF_WrData);
                end else begin
                    exp_wr = wr_q.pop_front();
                    if ({RF_Address, RF_WrData} !== exp_wr) begin
                        errors++;
                        $display("FAIL rf_write cyc %0d: got %h/%h required %h/%h", cyc, RF_Address, RF_WrData,
                                 exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]);
                    end
                end
            end
            if (RF_RdEn) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_read cyc %0d: got addr %h required no read", cyc, RF_Address);
                end else begin
                    exp_rd = rd_q.pop_front();
                    if (RF_Address !== exp_rd) begin
                        errors++;
                        $display("FAIL rf_read cyc %0d: got addr %h required %h", cyc, RF_Address, exp_rd);
                    end
                end
            end
            if (ALU_EN) begin
                checks++;
                if (fun_q.size() == 0) begin
                    errors++;
                    $display("FAIL alu_en cyc %0d: got fun %h required no start", cyc, ALU_FUN);
                end else begin
                    exp_fun = fun_q.pop_front();
                    if (ALU_FUN !== exp_fun) begin
                        errors++;
                        $display("FAIL alu_fun cyc %0d: got %h required %h", cyc, ALU_FUN, exp_fun);
                    end
                end
            end
            if (TX_D_VLD) begin
                tx_count++;
                tx_cyc.push_back(cyc);
                checks++;
                if (FIFO_FULL !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_when_full cyc %0d: got tx_vld=1 with fifo_full=%b required 0", cyc, FIFO_FULL);
                end
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte cyc %0d: got %h required no byte", cyc, TX_P_DATA);
                end else begin
                    exp_tx = tx_q.pop_front();
                    if (TX_P_DATA !== exp_tx) begin
                        errors++;
                        $display("FAIL tx_byte cyc %0d: got %h required %h", cyc, TX_P_DATA, exp_tx);
                    end
                end
            end
        end
    end

    // Register-file model: returns rd_val three cycles after each read strobe.
    initial begin
        forever begin
            @(negedge CLK);
            if (RF_RdEn && RST) begin
                repeat (3) @(posedge CLK);
                #1 RF_RdData = rd_val; RF_RdData_VLD = 1'b1;
                @(posedge CLK);
                #1 RF_RdData_VLD = 1'b0;
            end
        end
    end

    // ALU model: returns alu_val alu_lat cycles after each start strobe.
    initial begin
        forever begin
            @(negedge CLK);
            if (ALU_EN && RST) begin
                repeat (alu_lat) @(posedge CLK);
                #1 ALU_OUT = alu_val; ALU_OUT_VLD = 1'b1;
                @(posedge CLK);
                #1 ALU_OUT_VLD = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [DW-1:0] b);
        @(posedge CLK);
        #1 RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(posedge CLK);
        #1 RX_D_VLD = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size()) != 0 && n < maxc) begin
            @(posedge CLK);
            n++;
        end
        repeat (4) @(posedge CLK);
        checks++;
        if ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size()) != 0) begin
            errors++;
            $display("FAIL drain: got %0d wr %0d rd %0d alu %0d tx outstanding required 0",
                     wr_q.size(), rd_q.size(), fun_q.size(), tx_q.size());
            wr_q.delete(); rd_q.delete(); fun_q.delete(); tx_q.delete();
        end
    endtask

    task automatic wait_alu_vld(input int maxc);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!ALU_OUT_VLD && n < maxc);
        checks++;
        if (!ALU_OUT_VLD) begin
            errors++;
            $display("FAIL alu_wait: got no ALU_OUT_VLD within %0d cycles required one", maxc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr %h wr %b rd %b wd %h fun %h en %b gate %b tx %h vld %b required all 0",
                     RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD);
        end
        RST = 1'b1;
    endtask

    task automatic test_write();
        int tx0 = tx_count;
        wr_q.push_back({4'h5, 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_drain(50);
        checks++;
        if (tx_count != tx0) begin
            errors++;
            $display("FAIL write_no_tx: got %0d tx bytes required 0", tx_count - tx0);
        end
    endtask

    task automatic test_read();
        rd_val = 8'h5A;
        rd_q.push_back(4'h7);
        tx_q.push_back(8'h5A);
        send_byte(8'hBB); send_byte(8'h07);
        wait_drain(50);
    endtask

    task automatic test_alu_ops();
        alu_lat = 2;
        alu_val = 16'h0468;
        wr_q.push_back({4'h0, 8'h12});
        wr_q.push_back({4'h1, 8'h34});
        fun_q.push_back(4'h2);
        tx_q.push_back(8'h68);
        tx_q.push_back(8'h04);
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        wait_drain(50);
    endtask

    task automatic test_backpressure();
        int tx0;
        int rel;
        alu_lat = 3;
        alu_val = 16'h0468;
        FIFO_FULL = 1'b1;
        fun_q.push_back(4'h1);
        tx_q.push_back(8'h68);
        tx_q.push_back(8'h04);
        tx_cyc.delete();
        tx0 = tx_count;
        send_byte(8'hDD); send_byte(8'h01);
        wait_alu_vld(50);
        repeat (10) @(posedge CLK);
        checks++;
        if (tx_count != tx0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d tx bytes while full required 0", tx_count - tx0);
        end
        #1 FIFO_FULL = 1'b0;
        rel = cyc;
        wait_drain(50);
        checks++;
        if (tx_cyc.size() != 2 || tx_cyc[0] != rel || tx_cyc[1] != rel + 1) begin
            errors++;
            $display("FAIL backpressure_timing: got %0d bytes first cyc %0d required 2 bytes at cyc %0d,%0d",
                     tx_cyc.size(), (tx_cyc.size() > 0) ? tx_cyc[0] : -1, rel, rel + 1);
        end
    endtask

    task automatic test_idle_garbage();
        int tx0 = tx_count;
        // Register contents left by the earlier frames.
        @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrData, ALU_FUN, TX_P_DATA} !== {4'h1, 8'h34, 4'h1, 8'h04}) begin
            errors++;
            $display("FAIL idle_state_before: got %h/%h/%h/%h required 1/34/1/04", RF_Address, RF_WrData, ALU_FUN, TX_P_DATA);
        end
        send_byte(8'h77);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrData, ALU_FUN, TX_P_DATA} !== {4'h1, 8'h34, 4'h1, 8'h04} || tx_count != tx0) begin
            errors++;
            $display("FAIL idle_garbage: got %h/%h/%h/%h tx %0d required 1/34/1/04 tx 0",
                     RF_Address, RF_WrData, ALU_FUN, TX_P_DATA, tx_count - tx0);
        end
    endtask

    task automatic test_drop_alu_wait();
        alu_lat = 8;
        alu_val = 16'hA1B2;
        fun_q.push_back(4'h3);
        tx_q.push_back(8'hB2);
        tx_q.push_back(8'hA1);
        send_byte(8'hDD); send_byte(8'h03);
        send_byte(8'hAA);
        wait_drain(60);
        wr_q.push_back({4'h4, 8'h66});
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h66);
        wait_drain(50);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] burst [5];
        burst = '{8'hAA, 8'h02, 8'h11, 8'hBB, 8'h03};
        rd_val = 8'h99;
        wr_q.push_back({4'h2, 8'h11});
        rd_q.push_back(4'h3);
        tx_q.push_back(8'h99);
        @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            #1 RX_P_DATA = burst[i]; RX_D_VLD = 1'b1;
            @(posedge CLK);
        end
        #1 RX_D_VLD = 1'b0;
        wait_drain(50);
    endtask

    task automatic test_reset_mid_send();
        alu_lat = 2;
        alu_val = 16'hBEEF;
        FIFO_FULL = 1'b1;
        fun_q.push_back(4'h5);
        tx_q.push_back(8'hEF);
        send_byte(8'hDD); send_byte(8'h05);
        wait_alu_vld(50);
        @(posedge CLK);
        #1 FIFO_FULL = 1'b0;
        @(posedge CLK);
        #1 FIFO_FULL = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send: got addr %h wd %h fun %h gate %b tx %h vld %b required all 0",
                     RF_Address, RF_WrData, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD);
        end
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL send_lo_before_reset: got %0d bytes outstanding required 0", tx_q.size());
            tx_q.delete();
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        FIFO_FULL = 1'b0;
        wr_q.push_back({4'h9, 8'hC3});
        send_byte(8'hAA); send_byte(8'h09); send_byte(8'hC3);
        wait_drain(50);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_backpressure();
        test_idle_garbage();
        test_drop_alu_wait();
        test_back_to_back();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
